// File: rtl/mul28_pkg.sv
// mul28_pkg: shared constants, FSM state type and column geometry helper for
// the 28x28 column-load sequencer.
package mul28_pkg;

    // Default operand width and compressor latency.
    localparam int DEF_W            = 28;
    localparam int DEF_COMP_LATENCY = 4;

    // Number of partial-product columns and product width at the default width.
    localparam int NCOL = 2 * DEF_W - 1;
    localparam int NRES = 2 * DEF_W;

    // Sequencer states: idle, streaming rows, waiting on the compressor, holding the product.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Depth of the serial shift register in front of column j: the number of
    // partial-product bits that land in that column.
    function automatic int col_height(input int j, input int w = DEF_W);
        int ncol;
        ncol = 2 * w - 1;
        return ((j + 1) < (ncol - j)) ? (j + 1) : (ncol - j);
    endfunction

endpackage

// File: rtl/mul28_column_load_sequencer_if.sv
// mul28_column_load_sequencer_if: operand (in_*) and product (out_*) valid/ready
// channels of the column-load sequencer. The master modport belongs to the
// operand source / product consumer, the slave modport to the sequencer.
interface mul28_column_load_sequencer_if #(
    parameter int W = mul28_pkg::DEF_W
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_res;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res
    );

endinterface

// File: rtl/mul28_column_load_sequencer_row_gen.sv
// mul28_row_gen: combinational mapping of one partial-product row onto the
// compressor columns. Row r of a*b is a & {W{b[r]}} placed at column offset r;
// only the W columns it covers get a shift enable.
module mul28_row_gen
    import mul28_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ROW_W = $clog2(W)
) (
    input  logic [ROW_W-1:0] row,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-2:0]   col_bit,
    output logic [2*W-2:0]   col_shift
);

    localparam int COLS = 2 * W - 1;

    logic [COLS-1:0] a_ext;
    logic [COLS-1:0] window;
    logic            b_bit;

    // Shift the multiplicand and a W-wide enable window up to the row offset.
    always_comb begin
        a_ext     = COLS'(a);
        window    = COLS'({W{1'b1}});
        b_bit     = b[row];
        col_shift = window << row;
        col_bit   = (a_ext << row) & {COLS{b_bit}};
    end

endmodule

// File: rtl/mul28_column_load_sequencer.sv
// mul28_column_load_sequencer: accepts an operand pair, streams W partial-product
// rows into the per-column serial shift registers (one row per cycle), waits out
// the compressor latency, then captures and presents the 2W-bit product.
// Optional feature macro: MUL28_SELF_CHECK_EN adds an internal reference
// multiplier and the chk_err / chk_cnt outputs.
module mul28_column_load_sequencer
    import mul28_pkg::*;
#(
    parameter int W            = DEF_W,
    parameter int COMP_LATENCY = DEF_COMP_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mul28_column_load_sequencer_if.slave bus,
    output logic [2*W-2:0]               col_bit,
    output logic [2*W-2:0]               col_shift,
    input  logic [2*W-1:0]               res_in
`ifdef MUL28_SELF_CHECK_EN
    ,
    output logic                         chk_err,
    output logic [15:0]                  chk_cnt
`endif
);

    localparam int COLS  = 2 * W - 1;
    localparam int RES   = 2 * W;
    localparam int ROW_W = $clog2(W);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(W - 1);
    localparam logic [3:0]       LAT      = 4'(COMP_LATENCY);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [W-1:0]     a_q, b_q;
    logic             accept;
    logic             capture;
    logic             release_res;

    logic [W-1:0]     gen_a, gen_b;
    logic [COLS-1:0]  gen_bit, gen_shift;
    logic [COLS-1:0]  col_bit_d, col_shift_d;
    logic [COLS-1:0]  col_bit_q, col_shift_q;

    logic             out_valid_q;
    logic [RES-1:0]   out_res_q;

    // Next-state, counter and handshake decode for the sequencer FSM.
    always_comb begin
        // NOTE: every signal written here is given a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        row_d       = row_q;
        wcnt_d      = wcnt_q;
        accept      = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    row_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    wcnt_d  = '0;
                    state_d = WAIT;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            WAIT: begin
                if (wcnt_q == LAT) begin
                    capture = 1'b1;
                    wcnt_d  = '0;
                    state_d = HOLD;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    release_res = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands come straight from the port on the accept edge (row 0), from
    // the latched copies for the remaining rows.
    always_comb begin
        gen_a = accept ? bus.in_a : a_q;
        gen_b = accept ? bus.in_b : b_q;
    end

    mul28_row_gen #(
        .W     (W),
        .ROW_W (ROW_W)
    ) u_row_gen (
        .row       (row_d),
        .a         (gen_a),
        .b         (gen_b),
        .col_bit   (gen_bit),
        .col_shift (gen_shift)
    );

    // Column drive is only live for cycles that will be spent in LOAD.
    always_comb begin
        col_bit_d   = '0;
        col_shift_d = '0;
        if (state_d == LOAD) begin
            col_bit_d   = gen_bit;
            col_shift_d = gen_shift;
        end
    end

    // FSM state and row / wait counters.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Operand latch, loaded only on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are plain registers, not a memory array, so they take
        // the async reset like the rest of the state.
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q <= bus.in_a;
            b_q <= bus.in_b;
        end
    end

    // Registered column serial bits and shift enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_bit_q   <= '0;
            col_shift_q <= '0;
        end else begin
            col_bit_q   <= col_bit_d;
            col_shift_q <= col_shift_d;
        end
    end

    // Product capture from the compressor and result-port valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            out_res_q   <= res_in;
        end else if (release_res) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
    assign col_bit       = col_bit_q;
    assign col_shift     = col_shift_q;

`ifdef MUL28_SELF_CHECK_EN
    logic [RES-1:0] exp_q;
    logic           chk_err_q;
    logic [15:0]    chk_cnt_q;

    // Reference product latched at accept and compared with the compressor on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q     <= '0;
            chk_err_q <= 1'b0;
            chk_cnt_q <= '0;
        end else begin
            if (accept) begin
                exp_q <= RES'(bus.in_a) * RES'(bus.in_b);
            end
            if (capture && (res_in != exp_q)) begin
                chk_err_q <= 1'b1;
                if (chk_cnt_q != 16'hFFFF) begin
                    chk_cnt_q <= chk_cnt_q + 16'd1;
                end
            end
        end
    end

    assign chk_err = chk_err_q;
    assign chk_cnt = chk_cnt_q;
`endif

endmodule
